// File: rtl/tdm_demux_pkg.sv
// Shared types and defaults for the TDM demultiplexer.
// Optional misaligned-sync checking is enabled with TDM_DEMUX_SYNC_CHECK_EN.
package tdm_demux_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CHANNELS_DEFAULT = 4;

endpackage

// File: rtl/tdm_demux_if.sv
// Slot-stream input and parallel-output bundle for tdm_demux.
// master drives the serial slots; slave is the demultiplexer itself.
interface tdm_demux_if
    import tdm_demux_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEFAULT
) ();
    localparam int SEL_W = $clog2(CHANNELS);

    logic                en;
    logic                sync;
    logic                din;
    logic [SEL_W-1:0]    sel_out;
    logic [CHANNELS-1:0] y;
    logic [CHANNELS-1:0] frame;
    logic                frame_valid;
    logic                locked;
    logic                sync_err;

    modport master (
        output en, sync, din,
        input  sel_out, y, frame, frame_valid, locked, sync_err
    );

    modport slave (
        input  en, sync, din,
        output sel_out, y, frame, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: clear loads 1 (slot 0 was just written), advance wraps
// modulo CHANNELS; last flags the final slot of the frame.
module tdm_slot_ctr #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [SEL_W-1:0] sel,
    output logic             last
);
    logic [SEL_W-1:0] sel_q, sel_d;

    always_comb begin
        sel_d = sel_q;
        if (clear) begin
            sel_d = SEL_W'(1);
        end else if (advance) begin
            // CHANNELS is a power of two, so natural overflow is the wrap
            sel_d = sel_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel  = sel_q;
    assign last = (sel_q == SEL_W'(CHANNELS - 1));
endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: routes serial slots to channels and strobes each
// completed frame. Define TDM_DEMUX_SYNC_CHECK_EN to resync on misaligned sync.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux_if.slave   bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] y_q, y_d;
    logic [CHANNELS-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0] frame_q, frame_d;
    logic                frame_valid_q, frame_valid_d;
    logic                sync_err_q, sync_err_d;
    logic                locked_q, locked_d;

    logic                ctr_clear;
    logic                ctr_advance;
    logic [SEL_W-1:0]    sel;
    logic                last_slot;
    logic                wr_en;
    logic [SEL_W-1:0]    wr_sel;
    logic [CHANNELS-1:0] slot_we;
    logic                misaligned;

    tdm_slot_ctr #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_slot_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ctr_clear),
        .advance (ctr_advance),
        .sel     (sel),
        .last    (last_slot)
    );

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    assign misaligned = (state_q == RUN) && bus.en && bus.sync && (sel != '0);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        ctr_clear     = 1'b0;
        ctr_advance   = 1'b0;
        wr_en         = 1'b0;
        wr_sel        = sel;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        case (state_q)
            HUNT: begin
                if (bus.en && bus.sync) begin
                    state_d   = RUN;
                    wr_en     = 1'b1;
                    wr_sel    = '0;
                    ctr_clear = 1'b1;
                end
            end
            RUN: begin
                if (bus.en) begin
                    wr_en = 1'b1;
                    if (misaligned) begin
                        // Drop the partial frame and restart alignment on this slot
                        sync_err_d = 1'b1;
                        wr_sel     = '0;
                        ctr_clear  = 1'b1;
                    end else begin
                        ctr_advance = 1'b1;
                        if (last_slot) begin
                            frame_d       = {bus.din, shadow_q[CHANNELS-2:0]};
                            frame_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign locked_d = (state_d == RUN);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot
        assign slot_we[gi]  = wr_en && (wr_sel == SEL_W'(gi));
        assign y_d[gi]      = slot_we[gi] ? bus.din : y_q[gi];
        assign shadow_d[gi] = slot_we[gi] ? bus.din : shadow_q[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            y_q           <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            y_q           <= y_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
        end
    end

    assign bus.sel_out     = sel;
    assign bus.y           = y_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.locked      = locked_q;
    assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: stimulus pushes expected per-cycle state from
// a slot-level reference model; a monitor pops and compares after each edge.
module tb_tdm_demux;
    import tdm_demux_pkg::*;

    localparam int C = 4;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    localparam bit SYNC_CHK = 1'b1;
`else
    localparam bit SYNC_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tdm_demux_if #(.CHANNELS(C)) bus ();

    tdm_demux #(.CHANNELS(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         tag;
        logic [3:0] y;
        logic [3:0] frame;
        logic [1:0] sel;
        logic       fv;
        logic       lk;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   dut_frames = 0;
    int   m_frames = 0;

    // Reference model: a lock flag, the slot index as an integer, and one
    // remembered bit per channel.
    bit         m_locked;
    int         m_slot;
    bit         m_bits[C];
    logic [3:0] m_frame;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [3:0] pack_bits();
        logic [3:0] v;
        for (int i = 0; i < C; i++) v[i] = m_bits[i];
        return v;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_slot   = 0;
        for (int i = 0; i < C; i++) m_bits[i] = 1'b0;
        m_frame  = '0;
    endtask

    task automatic step(input bit en, input bit sync, input bit din);
        exp_t e;
        @(negedge clk);
        bus.en   = en;
        bus.sync = sync;
        bus.din  = din;
        e.fv  = 1'b0;
        e.err = 1'b0;
        if (en) begin
            if (!m_locked) begin
                if (sync) begin
                    m_locked  = 1'b1;
                    m_bits[0] = din;
                    m_slot    = 1;
                end
            end else if (SYNC_CHK && sync && m_slot != 0) begin
                e.err     = 1'b1;
                m_bits[0] = din;
                m_slot    = 1;
            end else begin
                m_bits[m_slot] = din;
                if (m_slot == C - 1) begin
                    m_frame = pack_bits();
                    e.fv    = 1'b1;
                    m_frames++;
                end
                m_slot = (m_slot + 1) % C;
            end
        end
        e.tag   = cyc + 1;
        e.y     = pack_bits();
        e.frame = m_frame;
        e.sel   = 2'(m_slot);
        e.lk    = m_locked;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_sel"},    32'(bus.sel_out),     32'd0);
        chk({name, "_y"},      32'(bus.y),           32'd0);
        chk({name, "_frame"},  32'(bus.frame),       32'd0);
        chk({name, "_fv"},     32'(bus.frame_valid), 32'd0);
        chk({name, "_locked"}, 32'(bus.locked),      32'd0);
        chk({name, "_err"},    32'(bus.sync_err),    32'd0);
    endtask

    task automatic send_frame(input logic [3:0] f, input bit gaps);
        for (int i = 0; i < C; i++) begin
            step(1'b1, i == 0, f[i]);
            if (gaps) begin
                step(1'b0, 1'b0, 1'b0);
                step(1'b0, 1'b1, ~f[i]);
            end
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares the DUT against the record targeted at this edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
                void'(exp_q.pop_front());
                chk("stale_record", 32'd1, 32'd0);
            end
            if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
                e = exp_q.pop_front();
                chk("y",           32'(bus.y),           32'(e.y));
                chk("sel_out",     32'(bus.sel_out),     32'(e.sel));
                chk("frame",       32'(bus.frame),       32'(e.frame));
                chk("frame_valid", 32'(bus.frame_valid), 32'(e.fv));
                chk("locked",      32'(bus.locked),      32'(e.lk));
                chk("sync_err",    32'(bus.sync_err),    32'(e.err));
            end
            if (bus.frame_valid) begin
                dut_frames++;
                $display("cyc %0d: frame %0d = %b", cyc, dut_frames, bus.frame);
            end
            if (bus.sync_err) $display("cyc %0d: sync_err pulse", cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
        bus.din  = 1'b0;
        model_reset();

        // Reset held with inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.en   = 1'b1;
            bus.sync = 1'($urandom_range(0, 1));
            bus.din  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_zero("rst_hold");
        end
        bus.en = 1'b0;
        bus.sync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Still hunting without sync
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Nominal frame, then framed data with bubbles
        send_frame(4'b1011, 1'b0);
        send_frame(4'b1011, 1'b1);
        send_frame(4'b0100, 1'b1);
        drain();
        chk("gap_frame", 32'(bus.frame), 32'h4);

        // Misaligned sync at sel_out == 2
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        drain();
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        chk("misalign_frame", 32'(bus.frame), 32'hC);
`else
        chk("misalign_frame", 32'(bus.frame), 32'h1);
`endif

        // Asynchronous reset mid-frame
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        drain();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, ($urandom % 8) == 0, 1'($urandom));
        end
        step(1'b0, 1'b0, 1'b0);
        drain();
        repeat (2) @(negedge clk);

        chk("frame_count", 32'(dut_frames), 32'(m_frames));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
